wb_core_bus_arbiter: RTL

Two-master, one-slave Wishbone-classic arbiter. It shares the single core memory bus between a core's instruction port (I) and data port (D) when the second memory is not built. It sits between the core and the Controller's core_* bus. Arbitration is round-robin and the grant is held until the granted transaction terminates.

---
 rtl/wb_arb_pkg.sv | 15 +
 rtl/wb_arb_timeout_ctr.sv | 39 +++
 rtl/wb_core_bus_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone core bus arbiter.
package wb_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    GNT_I = 3'b010,
    GNT_D = 3'b100
  } arb_state_t;

  localparam logic M_I = 1'b0;
  localparam logic M_D = 1'b1;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

endpackage

// File: rtl/wb_arb_timeout_ctr.sv
// Granted-cycle counter for the arbiter watchdog; expire_o is high while the
// count sits at TIMEOUT_CYCLES-1.
module wb_arb_timeout_ctr
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/wb_core_bus_arbiter.sv
// Round-robin Wishbone-classic arbiter sharing one slave between the core's
// I and D ports. Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module wb_core_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic                    i_cyc_i,
  input  logic                    i_stb_i,
  input  logic                    i_we_i,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb_i,
  input  logic [ADDR_WIDTH-1:0]   i_addr_i,
  input  logic [DATA_WIDTH-1:0]   i_data_i,
  output logic [DATA_WIDTH-1:0]   i_data_o,
  output logic                    i_ack_o,
  output logic                    i_err_o,
  input  logic                    d_cyc_i,
  input  logic                    d_stb_i,
  input  logic                    d_we_i,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb_i,
  input  logic [ADDR_WIDTH-1:0]   d_addr_i,
  input  logic [DATA_WIDTH-1:0]   d_data_i,
  output logic [DATA_WIDTH-1:0]   d_data_o,
  output logic                    d_ack_o,
  output logic                    d_err_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [DATA_WIDTH/8-1:0] s_wstrb_o,
  output logic [ADDR_WIDTH-1:0]   s_addr_o,
  output logic [DATA_WIDTH-1:0]   s_data_o,
  input  logic [DATA_WIDTH-1:0]   s_data_i,
  input  logic                    s_ack_i,
  output logic [1:0]              grant_o,
  output logic                    timeout_o
);

  arb_state_t state_q, state_d;
  logic       last_q, last_d;
  logic       req_i, req_d;
  logic       granted;
  logic       expire;

  assign req_i   = i_cyc_i & i_stb_i;
  assign req_d   = d_cyc_i & d_stb_i;
  assign granted = (state_q != IDLE);

`ifdef ARB_TIMEOUT_EN
  logic ctr_expire;
  logic timeout_q, timeout_d;

  wb_arb_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .clr_i    (!granted),
    .en_i     (granted && !s_ack_i),
    .expire_o (ctr_expire)
  );

  // A same-cycle ack takes precedence over the watchdog.
  assign expire    = granted & ctr_expire & ~s_ack_i;
  assign timeout_d = timeout_q | expire;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign expire             = 1'b0;
  assign timeout_o          = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= M_D;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (req_i && req_d) begin
          state_d = (last_q == M_D) ? GNT_I : GNT_D;
        end else if (req_i) begin
          state_d = GNT_I;
        end else if (req_d) begin
          state_d = GNT_D;
        end
      end
      GNT_I: begin
        if (s_ack_i) begin
          state_d = IDLE;
          last_d  = M_I;
        end else if (!i_cyc_i || expire) begin
          state_d = IDLE;
        end
      end
      GNT_D: begin
        if (s_ack_i) begin
          state_d = IDLE;
          last_d  = M_D;
        end else if (!d_cyc_i || expire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_wstrb_o = '0;
    s_addr_o  = '0;
    s_data_o  = '0;
    i_ack_o   = 1'b0;
    i_err_o   = 1'b0;
    d_ack_o   = 1'b0;
    d_err_o   = 1'b0;
    unique case (state_q)
      GNT_I: begin
        s_cyc_o   = i_cyc_i & ~expire;
        s_stb_o   = i_cyc_i & i_stb_i & ~expire;
        s_we_o    = i_we_i;
        s_wstrb_o = i_wstrb_i;
        s_addr_o  = i_addr_i;
        s_data_o  = i_data_i;
        i_ack_o   = s_ack_i;
        i_err_o   = expire;
      end
      GNT_D: begin
        s_cyc_o   = d_cyc_i & ~expire;
        s_stb_o   = d_cyc_i & d_stb_i & ~expire;
        s_we_o    = d_we_i;
        s_wstrb_o = d_wstrb_i;
        s_addr_o  = d_addr_i;
        s_data_o  = d_data_i;
        d_ack_o   = s_ack_i;
        d_err_o   = expire;
      end
      default: ;
    endcase
  end

  assign i_data_o = s_data_i;
  assign d_data_o = s_data_i;
  assign grant_o  = {state_q == GNT_D, state_q == GNT_I};

endmodule
